instr_fetch_unit: RTL and testbench

- Fetch-side initiator that drives the instruction memory read port: owns the PC and issues word-addressed reads.
- Captures returned instructions into a small prefetch FIFO and presents {PC, instruction} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing queued and in-flight fetches.
- Sits between the instruction memory and the decode stage of the 16-bit core.

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_prefetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The IF_PERF_CNT_EN build option uses the saturating helper below.
package if_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO holding fetch entries between instruction memory and decode.
// Flush empties the queue and takes priority over push and pop on the same edge.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Pointer and occupancy bookkeeping; flush rewinds everything to empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-cycle-latency reads to
// instruction memory and queues the returned words for decode.
// Build option IF_PERF_CNT_EN adds stall and flush counters as outputs.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              C_IMRead,
  output logic [ADDR_W-1:0] A_InstrAddress,
  input  logic [DATA_W-1:0] D_Instruction,
  output logic              C_IFValid,
  output logic [DATA_W-1:0] D_IFInstr,
  output logic [ADDR_W-1:0] D_IFPC,
  input  logic              C_IDReady,
  input  logic              C_Redirect,
  input  logic [ADDR_W-1:0] A_RedirectPC
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]       D_IFStallCnt,
  output logic [15:0]       D_IFFlushCnt
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;
  logic              credit, issue, push, pop;
  logic [CntW-1:0]   count;
  fetch_entry_t      head, rsp_entry;

  // Credit counts queued entries plus the outstanding read, so a push never
  // overflows. Only registered state feeds it; a pop frees credit next cycle.
  assign credit = (count + CntW'(inflight_q)) < CntW'(FIFO_DEPTH);
  assign issue  = credit & rst;

  assign C_IMRead       = issue;
  assign A_InstrAddress = pc_q;

  // Redirect beats everything: the queue is flushed, so no push or pop lands.
  assign push = inflight_q & ~kill_q & ~C_Redirect;
  assign pop  = C_IFValid & C_IDReady & ~C_Redirect;

  assign rsp_entry = '{pc: rsp_pc_q, instr: D_Instruction};

  // Next PC, response tag and kill tracking for the read issued this cycle.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    if (issue) begin
      rsp_pc_d = pc_q;
      pc_d     = pc_q + ADDR_W'(1);
    end
    if (C_Redirect) begin
      pc_d   = A_RedirectPC;
      // The read issued alongside the redirect returns next cycle for a stale PC.
      kill_d = issue;
    end
  end

  // Fetch control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  if_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (rsp_entry),
    .pop_i   (pop),
    .flush_i (C_Redirect),
    .head_o  (head),
    .count_o (count)
  );

  assign C_IFValid = (count != '0);
  assign D_IFInstr = head.instr;
  assign D_IFPC    = head.pc;

`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic [15:0] flush_amt;

  // Entries thrown away by a redirect: queued ones plus a response still live.
  assign flush_amt = 16'(count) + 16'(inflight_q & ~kill_q);

  // Saturating stall and flush counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (C_IFValid && !C_IDReady) stall_cnt_q <= sat_add16(stall_cnt_q, 16'd1);
      if (C_Redirect)              flush_cnt_q <= sat_add16(flush_cnt_q, flush_amt);
    end
  end

  assign D_IFStallCnt = stall_cnt_q;
  assign D_IFFlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a queue-based model of the fetch pipeline is
// checked every cycle, alongside hand-computed expectations for each scenario.
module tb_instr_fetch_unit;
  import if_pkg::*;

  localparam int unsigned Depth = 4;

  logic        clk, rst;
  logic        C_IMRead, C_IFValid, C_IDReady, C_Redirect;
  logic [15:0] A_InstrAddress, D_Instruction, D_IFInstr, D_IFPC, A_RedirectPC;
`ifdef IF_PERF_CNT_EN
  logic [15:0] D_IFStallCnt, D_IFFlushCnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .C_IMRead       (C_IMRead),
    .A_InstrAddress (A_InstrAddress),
    .D_Instruction  (D_Instruction),
    .C_IFValid      (C_IFValid),
    .D_IFInstr      (D_IFInstr),
    .D_IFPC         (D_IFPC),
    .C_IDReady      (C_IDReady),
    .C_Redirect     (C_Redirect),
    .A_RedirectPC   (A_RedirectPC)
`ifdef IF_PERF_CNT_EN
    ,
    .D_IFStallCnt   (D_IFStallCnt),
    .D_IFFlushCnt   (D_IFFlushCnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image: word at address a is a ^ A000 (so 0..3 hold A000..A003).
  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return a ^ 16'hA000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Memory: request seen before the edge, data driven just after it.
  logic        mreq;
  logic [15:0] maddr;
  initial begin
    D_Instruction = 16'hDEAD;
    forever begin
      @(negedge clk);
      mreq  = C_IMRead;
      maddr = A_InstrAddress;
      @(posedge clk);
      #1;
      D_Instruction = mreq ? instr_of(maddr) : 16'hDEAD;
    end
  end

  // Model: queue of fetched PCs, next PC, and the one outstanding response.
  logic [15:0] mq[$];
  logic [15:0] m_pc, m_pend_pc;
  bit          m_pend, m_live, m_rd, rst_seen;
  int          m_stall, m_flush;

  always @(negedge rst) rst_seen = 1'b1;

  always @(negedge clk) begin
    if (rst_seen || !rst) begin
      mq.delete();
      m_pc     = RESET_PC;
      m_pend   = 1'b0;
      m_live   = 1'b0;
      m_stall  = 0;
      m_flush  = 0;
      rst_seen = 1'b0;
    end
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", D_IFStallCnt, m_stall);
    chk("flush_cnt", D_IFFlushCnt, m_flush);
`endif
    if (!rst) begin
      chk("rst_imread", C_IMRead, 0);
      chk("rst_addr", A_InstrAddress, RESET_PC);
      chk("rst_valid", C_IFValid, 0);
      chk("rst_instr", D_IFInstr, 0);
      chk("rst_pc", D_IFPC, 0);
    end else begin
      m_rd = (mq.size() + int'(m_pend)) < int'(Depth);
      chk("imread", C_IMRead, m_rd);
      chk("addr", A_InstrAddress, m_pc);
      chk("valid", C_IFValid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("head_pc", D_IFPC, mq[0]);
        chk("head_instr", D_IFInstr, instr_of(mq[0]));
        if (!C_IDReady && m_stall < 65535) m_stall++;
      end
      if (C_Redirect) begin
        m_flush += mq.size() + int'(m_pend && m_live);
        if (m_flush > 65535) m_flush = 65535;
        mq.delete();
        m_pend    = m_rd;
        m_live    = 1'b0;
        m_pend_pc = m_pc;
        m_pc      = A_RedirectPC;
      end else begin
        if (mq.size() != 0 && C_IDReady) void'(mq.pop_front());
        if (m_pend && m_live) mq.push_back(m_pend_pc);
        m_pend    = m_rd;
        m_live    = 1'b1;
        m_pend_pc = m_pc;
        if (m_rd) m_pc = m_pc + 16'd1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  int nreq;
  logic [15:0] rdy_pat;

  initial begin
    rst = 1'b1; C_IDReady = 1'b1; C_Redirect = 1'b0; A_RedirectPC = '0;
    #2 rst = 1'b0;
    repeat (2) cyc();

    // Reset release, decode always ready.
    rst = 1'b1;
    neg(); chk("t1_c0_rd", C_IMRead, 1); chk("t1_c0_addr", A_InstrAddress, 16'h0000);
    cyc(); neg(); chk("t1_c1_addr", A_InstrAddress, 16'h0001); chk("t1_c1_vld", C_IFValid, 0);
    cyc(); neg(); chk("t1_c2_addr", A_InstrAddress, 16'h0002); chk("t1_c2_vld", C_IFValid, 1);
    chk("t1_c2_pc", D_IFPC, 16'h0000); chk("t1_c2_ins", D_IFInstr, 16'hA000);
    cyc(); neg(); chk("t1_c3_addr", A_InstrAddress, 16'h0003);
    chk("t1_c3_pc", D_IFPC, 16'h0001); chk("t1_c3_ins", D_IFInstr, 16'hA001);
    repeat (3) cyc();

    // Decode stalled: four requests fill the queue, then drain.
    rst = 1'b0; C_IDReady = 1'b0;
    cyc(); rst = 1'b1; nreq = 0;
    for (int c = 0; c < 8; c++) begin
      neg();
      nreq += int'(C_IMRead);
      if (c == 7) begin
        chk("t2_rd_full", C_IMRead, 0);
        chk("t2_head", D_IFPC, 16'h0000);
      end
      cyc();
    end
    chk("t2_nreq", nreq, 4);
    C_IDReady = 1'b1;
    neg(); chk("t2_c8_pc", D_IFPC, 16'h0000); chk("t2_c8_rd", C_IMRead, 0);
    cyc(); neg(); chk("t2_c9_pc", D_IFPC, 16'h0001); chk("t2_c9_addr", A_InstrAddress, 16'h0004);
    chk("t2_c9_rd", C_IMRead, 1);
    cyc(); neg(); chk("t2_c10_pc", D_IFPC, 16'h0002);
    cyc(); neg(); chk("t2_c11_pc", D_IFPC, 16'h0003);
    cyc(); neg(); chk("t2_c12_pc", D_IFPC, 16'h0004);

    // Redirect with three queued entries and one read in flight.
    cyc(); rst = 1'b0; C_IDReady = 1'b0;
    cyc(); rst = 1'b1;
    repeat (4) cyc();
    C_Redirect = 1'b1; A_RedirectPC = 16'h0040; C_IDReady = 1'b1;
    neg(); chk("t3_pre_rd", C_IMRead, 0); chk("t3_pre_pc", D_IFPC, 16'h0000);
    cyc(); C_Redirect = 1'b0;
    neg(); chk("t3_c5_vld", C_IFValid, 0); chk("t3_c5_addr", A_InstrAddress, 16'h0040);
    cyc(); neg(); chk("t3_c6_vld", C_IFValid, 0);
    cyc(); neg(); chk("t3_c7_vld", C_IFValid, 1); chk("t3_c7_pc", D_IFPC, 16'h0040);
    chk("t3_c7_ins", D_IFInstr, 16'hA040);

    // Back-to-back redirects: the second one wins and kills the first's read.
    cyc(); C_Redirect = 1'b1; A_RedirectPC = 16'h0080;
    cyc(); A_RedirectPC = 16'h0100;
    neg(); chk("t3b_a1_addr", A_InstrAddress, 16'h0080); chk("t3b_a1_vld", C_IFValid, 0);
    cyc(); C_Redirect = 1'b0;
    neg(); chk("t3b_a2_addr", A_InstrAddress, 16'h0100); chk("t3b_a2_vld", C_IFValid, 0);
    cyc(); neg(); chk("t3b_a3_vld", C_IFValid, 0);
    cyc(); neg(); chk("t3b_a4_pc", D_IFPC, 16'h0100); chk("t3b_a4_ins", D_IFInstr, 16'hA100);

    // PC wrap at the top of the address space.
    cyc(); C_Redirect = 1'b1; A_RedirectPC = 16'hFFFE;
    cyc(); C_Redirect = 1'b0;
    neg(); chk("t4_r1_addr", A_InstrAddress, 16'hFFFE);
    cyc(); neg(); chk("t4_r2_addr", A_InstrAddress, 16'hFFFF);
    cyc(); neg(); chk("t4_r3_addr", A_InstrAddress, 16'h0000); chk("t4_r3_pc", D_IFPC, 16'hFFFE);
    cyc(); neg(); chk("t4_r4_addr", A_InstrAddress, 16'h0001); chk("t4_r4_pc", D_IFPC, 16'hFFFF);
    cyc(); neg(); chk("t4_r5_pc", D_IFPC, 16'h0000); chk("t4_r5_ins", D_IFInstr, 16'hA000);

    // Irregular decode backpressure.
    rdy_pat = 16'b1011_0010_1110_0101;
    for (int i = 0; i < 16; i++) begin
      cyc();
      C_IDReady = rdy_pat[i];
    end
    cyc(); C_IDReady = 1'b1;
    repeat (3) cyc();

    // Mid-stream reset with a read outstanding; its response must be dropped.
    neg(); #1 rst = 1'b0;
    #1;
    chk("t5_rd", C_IMRead, 0); chk("t5_addr", A_InstrAddress, RESET_PC);
    chk("t5_vld", C_IFValid, 0); chk("t5_ins", D_IFInstr, 0); chk("t5_pc", D_IFPC, 0);
    cyc(); rst = 1'b1;
    neg(); chk("t5_c0_addr", A_InstrAddress, RESET_PC); chk("t5_c0_rd", C_IMRead, 1);
    cyc(); neg(); chk("t5_c1_vld", C_IFValid, 0);
    cyc(); neg(); chk("t5_c2_pc", D_IFPC, RESET_PC); chk("t5_c2_ins", D_IFInstr, 16'hA000);
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
